gpu_div_ctrl: RTL and testbench

GPU_DIV_CTRL -- requirements
Module: gpu_div_ctrl

---
 rtl/gpu_div_pkg.sv | 16 +
 rtl/div_sign_fix.sv | 11 +
 rtl/gpu_div_ctrl.sv | 168 ++++++++++++++++
 tb/tb_gpu_div_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_div_pkg.sv
// Shared types and constants for the GPU divide controller.
// Holds the FSM state encoding, the default register-index width and the divide-by-zero result.
package gpu_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } div_state_e;

    localparam int REGW_DEF = 5;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, 32 bits.
// Gives abs() when neg_i is the operand's sign bit, or fixes the quotient sign.
module div_sign_fix (
    input  logic [31:0] a_i,
    input  logic        neg_i,
    output logic [31:0] y_o
);

    assign y_o = neg_i ? (~a_i + 32'd1) : a_i;

endmodule

// File: rtl/gpu_div_ctrl.sv
// GPU divide-unit controller: issue, divider handshake, hazard stall, register writeback.
// Optional signed divide when GPU_DIV_SIGNED_EN is defined.
module gpu_div_ctrl
    import gpu_div_pkg::*;
#(
    parameter int REGW = REGW_DEF
) (
    input  logic            sys_clk,
    input  logic            resetl,
    input  logic            ce,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [31:0]     op_srcd,
    input  logic [31:0]     op_dstd,
    input  logic [REGW-1:0] op_reg,
    input  logic            op_signed,
    output logic            div_start,
    output logic [31:0]     srcd,
    output logic [31:0]     dstd,
    input  logic            div_active,
    input  logic [31:0]     quotient,
    output logic            wb_valid,
    input  logic            wb_ack,
    output logic [REGW-1:0] wb_reg,
    output logic [31:0]     wb_data,
    input  logic [REGW-1:0] hz_reg,
    input  logic            hz_use,
    output logic            stall,
    input  logic            rem_req,
    output logic            remrd,
    output logic            div_zero
);

    div_state_e      state_q, state_d;
    logic [31:0]     srcd_q, srcd_d;
    logic [31:0]     dstd_q, dstd_d;
    logic [31:0]     wbd_q, wbd_d;
    logic [REGW-1:0] reg_q, reg_d;
    logic            neg_q, neg_d;
    logic            zero_q, zero_d;
    logic            first_q, first_d;

    logic [31:0] iss_srcd;
    logic [31:0] iss_dstd;
    logic        iss_neg;
    logic [31:0] q_fix;

`ifdef GPU_DIV_SIGNED_EN
    div_sign_fix u_abs_s (
        .a_i   (op_srcd),
        .neg_i (op_signed & op_srcd[31]),
        .y_o   (iss_srcd)
    );

    div_sign_fix u_abs_d (
        .a_i   (op_dstd),
        .neg_i (op_signed & op_dstd[31]),
        .y_o   (iss_dstd)
    );

    div_sign_fix u_q_fix (
        .a_i   (quotient),
        .neg_i (neg_q),
        .y_o   (q_fix)
    );

    assign iss_neg = op_signed & (op_srcd[31] ^ op_dstd[31]);
`else
    logic sign_unused;

    assign iss_srcd    = op_srcd;
    assign iss_dstd    = op_dstd;
    assign iss_neg     = 1'b0;
    assign q_fix       = quotient;
    assign sign_unused = op_signed ^ neg_q;
`endif

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            srcd_q  <= '0;
            dstd_q  <= '0;
            wbd_q   <= '0;
            reg_q   <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            srcd_q  <= srcd_d;
            dstd_q  <= dstd_d;
            wbd_q   <= wbd_d;
            reg_q   <= reg_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        srcd_d  = srcd_q;
        dstd_d  = dstd_q;
        wbd_d   = wbd_q;
        reg_d   = reg_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        first_d = first_q;
        unique case (state_q)
            S_IDLE: begin
                if (ce && op_valid) begin
                    srcd_d = iss_srcd;
                    dstd_d = iss_dstd;
                    reg_d  = op_reg;
                    neg_d  = iss_neg;
                    zero_d = (op_srcd == 32'd0);
                    if (op_srcd == 32'd0) begin
                        wbd_d   = DIV_ZERO_Q;
                        state_d = S_WB;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                if (ce) begin
                    first_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // div_active may lag div_start by a cycle, so skip the first look
                if (ce) begin
                    first_d = 1'b0;
                    if (!first_q && !div_active) begin
                        wbd_d   = q_fix;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                if (ce && wb_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign op_ready  = (state_q == S_IDLE);
    assign div_start = (state_q == S_START);
    assign wb_valid  = (state_q == S_WB);
    assign div_zero  = (state_q == S_WB) && zero_q;
    assign srcd      = srcd_q;
    assign dstd      = dstd_q;
    assign wb_reg    = reg_q;
    assign wb_data   = wbd_q;
    assign remrd     = (state_q == S_IDLE) ? rem_req : 1'b0;
    assign stall     = (state_q != S_IDLE) &&
                       ((hz_use && (hz_reg == reg_q)) || rem_req);

endmodule

// File: tb/tb_gpu_div_ctrl.sv
// Directed bench for gpu_div_ctrl with a 16-cycle divider model.
// Covers reset, divide, divide-by-zero, hazards, writeback backpressure and the signed option.
module tb_gpu_div_ctrl;

    localparam int REGW = 5;

    logic            sys_clk = 1'b0;
    logic            resetl;
    logic            ce;
    logic            op_valid;
    logic            op_ready;
    logic [31:0]     op_srcd;
    logic [31:0]     op_dstd;
    logic [REGW-1:0] op_reg;
    logic            op_signed;
    logic            div_start;
    logic [31:0]     srcd;
    logic [31:0]     dstd;
    logic            div_active;
    logic [31:0]     quotient;
    logic            wb_valid;
    logic            wb_ack;
    logic [REGW-1:0] wb_reg;
    logic [31:0]     wb_data;
    logic [REGW-1:0] hz_reg;
    logic            hz_use;
    logic            stall;
    logic            rem_req;
    logic            remrd;
    logic            div_zero;

    int n_chk  = 0;
    int n_fail = 0;
    int n_start = 0;
    int n_wbv   = 0;
    int cnt     = 0;

    always #5 sys_clk = ~sys_clk;

    gpu_div_ctrl #(.REGW(REGW)) dut (
        .sys_clk    (sys_clk),
        .resetl     (resetl),
        .ce         (ce),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_srcd    (op_srcd),
        .op_dstd    (op_dstd),
        .op_reg     (op_reg),
        .op_signed  (op_signed),
        .div_start  (div_start),
        .srcd       (srcd),
        .dstd       (dstd),
        .div_active (div_active),
        .quotient   (quotient),
        .wb_valid   (wb_valid),
        .wb_ack     (wb_ack),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .hz_reg     (hz_reg),
        .hz_use     (hz_use),
        .stall      (stall),
        .rem_req    (rem_req),
        .remrd      (remrd),
        .div_zero   (div_zero)
    );

    // Divider model: busy for 16 ce cycles after a start pulse
    always @(posedge sys_clk) begin
        if (ce) begin
            if (div_start) begin
                cnt      <= 16;
                quotient <= dstd / srcd;
                n_start  <= n_start + 1;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
            end
        end
        if (ce && resetl && wb_valid) n_wbv <= n_wbv + 1;
    end

    assign div_active = (cnt != 0);

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_wb();
        int n;
        n = 0;
        while (!wb_valid && n < 100) begin
            tick();
            n++;
        end
        check("wb_timeout", {31'd0, wb_valid}, 32'd1);
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d,
                         input logic [REGW-1:0] r, input logic sg);
        op_srcd   = s;
        op_dstd   = d;
        op_reg    = r;
        op_signed = sg;
        op_valid  = 1'b1;
        tick();
        op_valid  = 1'b0;
    endtask

    initial begin
        int s0;
        resetl    = 1'b0;
        ce        = 1'b1;
        op_valid  = 1'b0;
        op_srcd   = '0;
        op_dstd   = '0;
        op_reg    = '0;
        op_signed = 1'b0;
        wb_ack    = 1'b0;
        hz_reg    = '0;
        hz_use    = 1'b0;
        rem_req   = 1'b0;
        quotient  = '0;
        tick();
        tick();
        check("rst_ready",  {31'd0, op_ready},  32'd1);
        check("rst_start",  {31'd0, div_start}, 32'd0);
        check("rst_wbv",    {31'd0, wb_valid},  32'd0);
        check("rst_dz",     {31'd0, div_zero},  32'd0);
        check("rst_stall",  {31'd0, stall},     32'd0);
        check("rst_srcd",   srcd,    32'd0);
        check("rst_dstd",   dstd,    32'd0);
        check("rst_wbdata", wb_data, 32'd0);
        check("rst_wbreg",  {27'd0, wb_reg}, 32'd0);
        resetl = 1'b1;
        rem_req = 1'b1;
        #1;
        check("idle_remrd", {31'd0, remrd}, 32'd1);
        hz_use = 1'b1;
        hz_reg = 5'd0;
        #1;
        check("idle_stall", {31'd0, stall}, 32'd0);
        rem_req = 1'b0;
        hz_use  = 1'b0;

        // ce low: op must not be accepted
        ce = 1'b0;
        op_valid = 1'b1;
        op_srcd  = 32'd7;
        op_dstd  = 32'd100;
        tick();
        check("ce0_ready", {31'd0, op_ready}, 32'd1);
        op_valid = 1'b0;
        ce = 1'b1;

        // 100 / 7 -> 14
        s0 = n_start;
        issue(32'd7, 32'd100, 5'd3, 1'b0);
        check("st_start", {31'd0, div_start}, 32'd1);
        check("st_ready", {31'd0, op_ready},  32'd0);
        check("st_srcd",  srcd, 32'd7);
        check("st_dstd",  dstd, 32'd100);
        tick();
        check("wt_start", {31'd0, div_start}, 32'd0);
        hz_use = 1'b1;
        hz_reg = 5'd3;
        #1;
        check("hz_match", {31'd0, stall}, 32'd1);
        hz_reg = 5'd4;
        #1;
        check("hz_diff", {31'd0, stall}, 32'd0);
        hz_use  = 1'b0;
        rem_req = 1'b1;
        #1;
        check("rem_stall", {31'd0, stall}, 32'd1);
        check("rem_remrd", {31'd0, remrd}, 32'd0);
        rem_req = 1'b0;
        wait_wb();
        check("d_wbreg",  {27'd0, wb_reg}, 32'd3);
        check("d_wbdata", wb_data, 32'd14);
        check("d_dz",     {31'd0, div_zero}, 32'd0);
        check("d_pulses", n_start - s0, 32'd1);

        // backpressure: ack low for 5 ce, op_valid presented meanwhile
        op_valid = 1'b1;
        op_srcd  = 32'd0;
        op_dstd  = 32'd5;
        op_reg   = 5'd6;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_wbv",  {31'd0, wb_valid}, 32'd1);
            check("bp_data", wb_data, 32'd14);
            check("bp_reg",  {27'd0, wb_reg}, 32'd3);
            check("bp_rdy",  {31'd0, op_ready}, 32'd0);
        end
        // ack together with a pending op: only WB completes
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("ack_idle", {31'd0, op_ready}, 32'd1);
        check("ack_wbv",  {31'd0, wb_valid}, 32'd0);
        // pending op is 5 / 0
        s0 = n_start;
        tick();
        op_valid = 1'b0;
        check("dz_wbv",   {31'd0, wb_valid}, 32'd1);
        check("dz_data",  wb_data, 32'hFFFFFFFF);
        check("dz_flag",  {31'd0, div_zero}, 32'd1);
        check("dz_reg",   {27'd0, wb_reg}, 32'd6);
        tick();
        check("dz_nostart", n_start - s0, 32'd0);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("dz_clr", {31'd0, div_zero}, 32'd0);

        // reset in WAIT with ce low
        issue(32'd5, 32'd50, 5'd9, 1'b0);
        tick();
        tick();
        tick();
        ce = 1'b0;
        resetl = 1'b0;
        tick();
        check("mr_ready", {31'd0, op_ready}, 32'd1);
        check("mr_wbv",   {31'd0, wb_valid}, 32'd0);
        check("mr_data",  wb_data, 32'd0);
        resetl = 1'b1;
        ce = 1'b1;
        s0 = n_wbv;
        repeat (30) tick();
        check("mr_nowb", n_wbv - s0, 32'd0);

        // op_signed: -100 / 7
        issue(32'd7, 32'hFFFFFF9C, 5'd2, 1'b1);
`ifdef GPU_DIV_SIGNED_EN
        check("sg_dstd", dstd, 32'd100);
        check("sg_srcd", srcd, 32'd7);
        wait_wb();
        check("sg_data", wb_data, 32'hFFFFFFF2);
`else
        check("us_dstd", dstd, 32'hFFFFFF9C);
        check("us_srcd", srcd, 32'd7);
        wait_wb();
        check("us_data", wb_data, 32'd613566742);
`endif
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("end_ready", {31'd0, op_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
